// File: rtl/demux_rr_sched_pkg.sv
// Shared state type, defaults and select decode for the round-robin demux scheduler.
// Imported by the interface, the picker and the top-level FSM.
package demux_sched_pkg;

    localparam int DEF_N_OUT = 8;
    localparam int DEF_SEL_W = $clog2(DEF_N_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        XFER = 2'd2
    } state_t;

    function automatic logic [DEF_N_OUT-1:0] onehot(
        input logic [DEF_SEL_W-1:0] s
    );
        logic [DEF_N_OUT-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_rr_sched_if.sv
// Upstream stream, per-sink handshake and status bundle of the scheduler.
// master = environment (source/sinks), slave = scheduler.
interface demux_rr_sched_if
    import demux_sched_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int SEL_W = $clog2(N_OUT),
    parameter int DW    = 1
);

    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic [N_OUT-1:0] en_mask;
    logic [N_OUT-1:0] out_ready;
    logic [N_OUT-1:0] out_valid;
    logic [DW-1:0]    out_data;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             stall_evt;

    modport master (
        output in_valid,
        output in_data,
        output en_mask,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  sel,
        input  busy,
        input  stall_evt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  en_mask,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output sel,
        output busy,
        output stall_evt
    );

endinterface

// File: rtl/demux_rr_sched_rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr,
// wrapping through ptr itself last.
module rr_pick
    import demux_sched_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic [N_OUT-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 1; i <= N_OUT; i++) begin
            // truncation is the modulo because N_OUT is a power of two
            cand = SEL_W'(int'(ptr) + i);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler driving a 1:N demux: bursts of BURST beats per grant,
// with a stall timeout that rotates away from a sink that stops accepting.
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int N_OUT   = DEF_N_OUT,
    parameter int SEL_W   = $clog2(N_OUT),
    parameter int DW      = 1,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    demux_rr_sched_if.slave bus
);

    localparam int BW = $clog2(BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_nxt;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_nxt;
    logic [BW-1:0]    beat_cnt;
    logic [BW-1:0]    beat_nxt;
    logic [TW-1:0]    stall_cnt;
    logic [TW-1:0]    stall_nxt;
    logic             evt_q;
    logic             evt_nxt;

    logic [N_OUT-1:0] cand;
    logic             hit;
    logic [SEL_W-1:0] win;
    logic             any_en;
    logic             en_sel;
    logic             rdy_sel;
    logic             in_ready;
    logic             beat;
    logic [N_OUT-1:0] sel_oh;

    assign cand    = bus.en_mask & bus.out_ready;
    assign any_en  = |bus.en_mask;
    assign en_sel  = bus.en_mask[sel_q];
    assign rdy_sel = bus.out_ready[sel_q];

    assign in_ready = (state == XFER) & en_sel & rdy_sel;
    assign beat     = in_ready & bus.in_valid;
    assign sel_oh   = N_OUT'(1) << sel_q;

    rr_pick #(
        .N_OUT(N_OUT),
        .SEL_W(SEL_W)
    ) u_pick (
        .req(cand),
        .ptr(ptr_q),
        .hit(hit),
        .idx(win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            ptr_q     <= SEL_W'(N_OUT - 1);
            beat_cnt  <= '0;
            stall_cnt <= '0;
            evt_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_q     <= sel_nxt;
            ptr_q     <= ptr_nxt;
            beat_cnt  <= beat_nxt;
            stall_cnt <= stall_nxt;
            evt_q     <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        ptr_nxt   = ptr_q;
        beat_nxt  = beat_cnt;
        stall_nxt = stall_cnt;
        evt_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_en)
                    state_nxt = SEEK;
            end
            SEEK: begin
                if (!any_en) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    sel_nxt   = win;
                    ptr_nxt   = win;
                    beat_nxt  = '0;
                    stall_nxt = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                // a disabled sink ends the burst before any beat is taken
                if (!en_sel) begin
                    state_nxt = any_en ? SEEK : IDLE;
                end else if (beat) begin
                    stall_nxt = '0;
                    if (beat_cnt != BW'(BURST))
                        beat_nxt = beat_cnt + BW'(1);
                    if (beat_cnt == BW'(BURST - 1))
                        state_nxt = SEEK;
                end else if (bus.in_valid) begin
                    if (stall_cnt != TW'(TIMEOUT))
                        stall_nxt = stall_cnt + TW'(1);
                    if (stall_cnt == TW'(TIMEOUT - 1)) begin
                        evt_nxt   = 1'b1;
                        state_nxt = SEEK;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = sel_oh & {N_OUT{beat}};
    assign bus.out_data  = bus.in_data;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state != IDLE);
    assign bus.stall_evt = evt_q;

endmodule
